// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the ALU control decoder), FSM states, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_DIV = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_AND = 4'b1000,
    ALU_OR  = 4'b1001,
    ALU_XOR = 4'b1010,
    ALU_NOR = 4'b1011,
    ALU_SLT = 4'b1110
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed mul (shift-add) / div (restoring) engine on operand magnitudes, sign fix-up on output.
// Latency: WIDTH i_step cycles after i_load; o_lo/o_hi are sign-corrected combinationally from the final state.
// Backpressure: none; the owning FSM paces it with i_load / i_step and watches o_last.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             o_dbz
);

  logic [WIDTH-1:0] r_hi, r_lo, r_m, r_a;
  logic [SHW-1:0]   r_cnt;
  logic             r_is_div, r_neg, r_bz;

  logic [WIDTH-1:0]   w_ma, w_mb;
  logic [WIDTH:0]     w_sum, w_rsh, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_ma = i_a[WIDTH-1] ? -i_a : i_a;
  assign w_mb = i_b[WIDTH-1] ? -i_b : i_b;

  // mul step: add multiplicand into the high half when the multiplier LSB is set, then shift right
  assign w_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {WIDTH{1'b0}})};
  // div step: shift next dividend bit into the partial remainder and trial-subtract the divisor
  assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_rsh - {1'b0, r_m};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign o_last     = (r_cnt == SHW'(WIDTH - 1));
  assign o_dbz      = r_is_div & r_bz;

  // Operand capture on load, one iteration per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_bz     <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_is_div <= i_is_div;
      r_a      <= i_a;
      r_neg    <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
      r_bz     <= (i_b == '0);
      r_hi     <= '0;
      r_lo     <= i_is_div ? w_ma : w_mb;
      r_m      <= i_is_div ? w_mb : w_ma;
    end else if (i_step) begin
      r_cnt <= r_cnt + SHW'(1);
      if (r_is_div) begin
        r_hi <= w_diff[WIDTH] ? w_rsh[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  // Sign fix-up: product sign is sa^sb; quotient sign sa^sb, remainder follows the dividend
  always_comb begin
    o_lo = '0;
    o_hi = '0;
    if (!r_is_div) begin
      {o_hi, o_lo} = w_prod_fix;
    end else if (r_bz) begin
      o_lo = '1;
      o_hi = r_a;
    end else begin
      o_lo = r_neg ? -r_lo : r_lo;
      o_hi = r_a[WIDTH-1] ? -r_hi : r_hi;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle ops plus optional iterative signed mul/div (build macro ALU_MULDIV_EN).
// Latency: 1 cycle for single-cycle ops; WIDTH+2 edges (accept through done) for mul/div.
// Backpressure: o_busy high during mul/div; i_start is ignored while busy, accepted in IDLE or DONE.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_operation,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SHW-1:0]   i_shamt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_div_by_zero,
  output logic             o_illegal
);

  alu_state_t r_state, w_next;
  logic             w_accept, w_is_muldiv;
  logic [WIDTH-1:0] w_sc_res;
  logic             w_sc_ill;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_dbz, r_illegal;

`ifdef ALU_MULDIV_EN
  logic             w_eng_step, w_eng_last, w_eng_dbz;
  logic [WIDTH-1:0] w_eng_lo, w_eng_hi;

  assign w_is_muldiv = (i_operation == ALU_MUL) || (i_operation == ALU_DIV);

  alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept & w_is_muldiv),
    .i_is_div (i_operation == ALU_DIV),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_step   (w_eng_step),
    .o_last   (w_eng_last),
    .o_lo     (w_eng_lo),
    .o_hi     (w_eng_hi),
    .o_dbz    (w_eng_dbz)
  );
`else
  assign w_is_muldiv = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: IDLE/DONE accept a new op, mul/div iterate until the engine's last step, then FIX
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (!i_start)                       w_next = ST_IDLE;
`ifdef ALU_MULDIV_EN
        else if (i_operation == ALU_MUL)    w_next = ST_MUL;
        else if (i_operation == ALU_DIV)    w_next = ST_DIV;
`endif
        else                                w_next = ST_DONE;
      end
`ifdef ALU_MULDIV_EN
      ST_MUL, ST_DIV: if (w_eng_last) w_next = ST_FIX;
      ST_FIX:         w_next = ST_DONE;
`endif
      default:        w_next = ST_IDLE;
    endcase
  end

  // State-decoded controls
  always_comb begin
    w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    o_done   = (r_state == ST_DONE);
`ifdef ALU_MULDIV_EN
    w_eng_step = (r_state == ST_MUL) || (r_state == ST_DIV);
    o_busy     = w_eng_step || (r_state == ST_FIX);
`else
    o_busy     = 1'b0;
`endif
  end

  // Single-cycle datapath; anything unmapped (including mul/div when not built) is illegal
  always_comb begin
    w_sc_res = '0;
    w_sc_ill = 1'b0;
    case (i_operation)
      ALU_ADD: w_sc_res = i_a + i_b;
      ALU_SUB: w_sc_res = i_a - i_b;
      ALU_SLL: w_sc_res = i_b << i_shamt;
      ALU_SRL: w_sc_res = i_b >> i_shamt;
      ALU_AND: w_sc_res = i_a & i_b;
      ALU_OR:  w_sc_res = i_a | i_b;
      ALU_XOR: w_sc_res = i_a ^ i_b;
      ALU_NOR: w_sc_res = ~(i_a | i_b);
      ALU_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: w_sc_ill = 1'b1;
    endcase
  end

  // Output registers: single-cycle results land on the accept edge, mul/div on the FIX edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_dbz     <= 1'b0;
      r_illegal <= 1'b0;
      if (!w_is_muldiv) begin
        r_result    <= w_sc_res;
        r_result_hi <= '0;
        r_zero      <= (w_sc_res == '0);
        r_illegal   <= w_sc_ill;
      end
`ifdef ALU_MULDIV_EN
    end else if (r_state == ST_FIX) begin
      r_result    <= w_eng_lo;
      r_result_hi <= w_eng_hi;
      r_zero      <= (w_eng_lo == '0);
      r_dbz       <= w_eng_dbz;
`endif
    end
  end

  assign o_result      = r_result;
  assign o_result_hi   = r_result_hi;
  assign o_zero        = r_zero;
  assign o_div_by_zero = r_dbz;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table for single-cycle ops plus hand sequences.
// Latency: checks 1-cycle done for simple ops and WIDTH+1 edges after accept for mul/div.
// Backpressure: checks start-while-busy is ignored and busy/done exclusivity.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [3:0]  i_operation;
  logic [31:0] i_a, i_b;
  logic [4:0]  i_shamt;
  logic        o_busy, o_done, o_zero, o_div_by_zero, o_illegal;
  logic [31:0] o_result, o_result_hi;

  int n_tests = 0;
  int n_fail  = 0;
  logic busy_seen = 1'b0;

  alu_multicycle #(.WIDTH(32), .SHW(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_operation   (i_operation),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_shamt       (i_shamt),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_result_hi   (o_result_hi),
    .o_zero        (o_zero),
    .o_div_by_zero (o_div_by_zero),
    .o_illegal     (o_illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_busy) busy_seen = 1'b1;
    if (o_done && o_busy) begin
      n_fail++;
      $display("FAIL busy_done_exclusive: busy=%0b done=%0b, required not both high", o_busy, o_done);
    end
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    i_start = 1'b1; i_operation = op; i_a = a; i_b = b; i_shamt = sh;
    @(posedge clk);
    #1 i_start = 1'b0;
  endtask

  // Waits (bounded) for done after an accept; optionally pulses an add start at edge pulse_at
  task automatic wait_done(input int pulse_at, output int n, output int nbusy_low);
    n = 0;
    nbusy_low = 0;
    while (!o_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == pulse_at) begin
        i_start = 1'b1; i_operation = 4'b0000; i_a = 32'd1; i_b = 32'd1;
      end
      if (n == pulse_at + 1) i_start = 1'b0;
      if (!o_done && !o_busy) nbusy_low++;
    end
  endtask

  initial begin
    int n, nbl;
    rst_n = 1'b0; i_start = 1'b0; i_operation = '0; i_a = '0; i_b = '0; i_shamt = '0;

    // table: op, a, b, shamt, result, zero, illegal
    vecs.push_back('{4'b0000, 32'd7,        32'd5,        5'd0,  32'd12,       1'b0, 1'b0});
    vecs.push_back('{4'b0000, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        1'b1, 1'b0});
    vecs.push_back('{4'b0001, 32'd3,        32'd5,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{4'b0100, 32'h0000FFFF, 32'd1,        5'd31, 32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{4'b0101, 32'h0000FFFF, 32'h80000000, 5'd31, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{4'b0101, 32'd0,        32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0});
    vecs.push_back('{4'b1000, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 1'b0, 1'b0});
    vecs.push_back('{4'b1001, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 1'b0, 1'b0});
    vecs.push_back('{4'b1010, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h00000FF0, 1'b0, 1'b0});
    vecs.push_back('{4'b1011, 32'hFFFF0000, 32'h0000FFFF, 5'd0,  32'd0,        1'b1, 1'b0});
    vecs.push_back('{4'b1011, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'hFFFF000F, 1'b0, 1'b0});
    vecs.push_back('{4'b1110, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1'b0});
    vecs.push_back('{4'b1110, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        1'b1, 1'b0});
    vecs.push_back('{4'b1111, 32'd3,        32'd4,        5'd0,  32'd0,        1'b1, 1'b1});
    vecs.push_back('{4'b0110, 32'd3,        32'd4,        5'd0,  32'd0,        1'b1, 1'b1});
`ifndef ALU_MULDIV_EN
    vecs.push_back('{4'b0010, 32'd3,        32'd4,        5'd0,  32'd0,        1'b1, 1'b1});
    vecs.push_back('{4'b0011, 32'd9,        32'd2,        5'd0,  32'd0,        1'b1, 1'b1});
`endif

    // reset state
    #12;
    check("rst_busy",   64'(o_busy),        64'd0);
    check("rst_done",   64'(o_done),        64'd0);
    check("rst_result", {o_result_hi, o_result}, 64'd0);
    check("rst_flags",  64'({o_zero, o_div_by_zero, o_illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add then back-to-back sub issued in the DONE cycle
    @(negedge clk);
    i_start = 1'b1; i_operation = 4'b0000; i_a = 32'd7; i_b = 32'd5; i_shamt = '0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_add_done",   64'(o_done),   64'd1);
    check("b2b_add_result", 64'(o_result), 64'd12);
    check("b2b_add_zero",   64'(o_zero),   64'd0);
    i_operation = 4'b0001; i_a = 32'h1234; i_b = 32'h1234;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("b2b_sub_done",   64'(o_done),   64'd1);
    check("b2b_sub_result", 64'(o_result), 64'd0);
    check("b2b_sub_zero",   64'(o_zero),   64'd1);
    @(negedge clk);
    check("done_to_idle",   64'(o_done),   64'd0);

    // single-cycle vector table
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      @(negedge clk);
      check($sformatf("vec%0d_done", i),   64'(o_done),      64'd1);
      check($sformatf("vec%0d_busy", i),   64'(o_busy),      64'd0);
      check($sformatf("vec%0d_result", i), 64'(o_result),    64'(vecs[i].res));
      check($sformatf("vec%0d_hi", i),     64'(o_result_hi), 64'd0);
      check($sformatf("vec%0d_zero", i),   64'(o_zero),      64'(vecs[i].zero));
      check($sformatf("vec%0d_illegal", i), 64'(o_illegal),  64'(vecs[i].ill));
      check($sformatf("vec%0d_dbz", i),    64'(o_div_by_zero), 64'd0);
    end

`ifdef ALU_MULDIV_EN
    // mul -3 * 7 with an ignored add start during iteration 5
    issue(4'b0010, 32'hFFFFFFFD, 32'd7, 5'd0);
    wait_done(5, n, nbl);
    check("mul_latency",  64'(n),           64'd33);
    check("mul_busy_gap", 64'(nbl),         64'd0);
    check("mul_lo",       64'(o_result),    64'hFFFFFFEB);
    check("mul_hi",       64'(o_result_hi), 64'hFFFFFFFF);
    check("mul_illegal_cleared", 64'(o_illegal), 64'd0);
    @(negedge clk);
    check("mul_done_pulse", 64'(o_done), 64'd0);

    // mul most-negative squared: 2^62
    issue(4'b0010, 32'h80000000, 32'h80000000, 5'd0);
    wait_done(-10, n, nbl);
    check("mul_min_prod", {o_result_hi, o_result}, 64'h4000000000000000);

    // div -17 / 5
    issue(4'b0011, 32'hFFFFFFEF, 32'd5, 5'd0);
    wait_done(-10, n, nbl);
    check("div_latency", 64'(n),           64'd33);
    check("div_q",       64'(o_result),    64'hFFFFFFFD);
    check("div_r",       64'(o_result_hi), 64'hFFFFFFFE);
    check("div_dbz",     64'(o_div_by_zero), 64'd0);

    // div 100 / -7: q=-14, r=2
    issue(4'b0011, 32'd100, 32'hFFFFFFF9, 5'd0);
    wait_done(-10, n, nbl);
    check("div2_q", 64'(o_result),    64'hFFFFFFF2);
    check("div2_r", 64'(o_result_hi), 64'd2);

    // div 9 / 0
    issue(4'b0011, 32'd9, 32'd0, 5'd0);
    wait_done(-10, n, nbl);
    check("dbz_latency", 64'(n),             64'd33);
    check("dbz_q",       64'(o_result),      64'hFFFFFFFF);
    check("dbz_r",       64'(o_result_hi),   64'd9);
    check("dbz_flag",    64'(o_div_by_zero), 64'd1);

    // flag clears on next accept
    issue(4'b0000, 32'd7, 32'd5, 5'd0);
    @(negedge clk);
    check("dbz_cleared", 64'(o_div_by_zero), 64'd0);
    check("post_dbz_add", 64'(o_result),     64'd12);

    // start mul, reset during iteration 10
    issue(4'b0010, 32'd2, 32'd3, 5'd0);
    repeat (10) @(posedge clk);
`else
    issue(4'b0000, 32'd7, 32'd5, 5'd0);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(o_busy),   64'd0);
    check("abort_done",   64'(o_done),   64'd0);
    check("abort_result", {o_result_hi, o_result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'b0000, 32'd1, 32'd1, 5'd0);
    @(negedge clk);
    check("post_rst_done",   64'(o_done),   64'd1);
    check("post_rst_result", 64'(o_result), 64'd2);

`ifndef ALU_MULDIV_EN
    check("busy_never", 64'(busy_seen), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Execution-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder and executes it on two WIDTH-bit operands. Single-cycle ops (add, sub, shifts, logic, slt) complete in one cycle. Signed mul and div run on an iterative shift-add / restoring engine with a start/busy/done handshake, so the pipeline controller can stall on them. Sits between the register-file read ports and the writeback mux.

## Interface
- WIDTH, 32, operand/result width (≥8, power of two)
- SHW, $clog2(WIDTH), shift-amount width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted only when busy=0
- operation  in  4  op code: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 sll, 0101 srl, 1000 and, 1001 or, 1010 xor, 1011 nor, 1110 slt; all others illegal
- a, b  in  WIDTH  operands (a=rs, b=rt)
- shamt  in  SHW  shift amount
- busy  out  1  high while a mul/div is in progress
- done  out  1  one-cycle pulse when result is valid
- result  out  WIDTH  low result / quotient
- result_hi  out  WIDTH  mul high word / div remainder; 0 for other ops
- zero  out  1  result==0, registered with result
- div_by_zero  out  1  set with done for div with b==0
- illegal  out  1  set with done for an unmapped code

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. busy = (state ∈ {MUL, DIV, FIX}).
- Accepting start (state IDLE or DONE) latches operation, a, b and shamt. Later input changes do not affect the op.
- Single-cycle op: state→DONE, and result, result_hi and flags are registered on the accept edge.
- DONE with no start→IDLE. DONE with start→accept (back-to-back issue, throughput 1/cycle).
- add/sub: modulo 2^WIDTH, no overflow flag.
- sll: b << shamt. srl: b >> shamt (logical).
- and, or, xor, nor: bitwise.
- slt: result = {0…, signed(a)<signed(b)}.
- mul: signed; operand magnitudes go to MUL for WIDTH iterations, then FIX applies sign; 2·WIDTH product goes to {result_hi, result}.
- div: signed, truncating. Quotient in result; remainder in result_hi with the sign of the dividend. DIV runs WIDTH iterations, then FIX.
- Div by zero: result=all ones, result_hi=a, div_by_zero=1. Full latency is kept.
- Illegal code: result=0, result_hi=0, illegal=1, single-cycle.
- start while busy: ignored, no side effects.
- Outputs hold their values until the next completion. Flags clear on the next accept.

## Timing
- Reset (async, immediate): state=IDLE; busy, done, result, result_hi, zero, div_by_zero and illegal all 0.
- Accept edge E0. Single-cycle ops: done=1 during the cycle after E0.
- mul/div: busy=1 from E0 through E(WIDTH+1); done=1 during the cycle after E(WIDTH+1), i.e. WIDTH+2 edges including E0. With WIDTH=32, done is visible 33 cycles after the start cycle.
- rst_n low mid-operation: abort immediately, with no done pulse and no partial result.
- done and busy are never both high.

## Configuration
- ALU_MULDIV_EN defined: full behaviour above.
- ALU_MULDIV_EN undefined:
  - MUL, DIV, FIX states and the iterative engine are not built, and busy is tied 0.
  - Codes 0010 and 0011 are illegal (single-cycle, illegal=1).

## Structure
- Shared package alu_pkg:
  - op-code localparams / enum alu_op_t, shared with the ALU control decoder
  - state enum alu_state_t
  - default WIDTH
- Sub-module alu_muldiv_iter holds the iterative signed mul/div engine: magnitude datapath, iteration counter and sign fix-up. It is instantiated only under ALU_MULDIV_EN. The top module owns the FSM, single-cycle datapath and output registers.

## Test plan
- add a=7,b=5 → result=12, zero=0, done one cycle after accept. Then sub a=b=0x1234 issued back-to-back in the DONE cycle → result=0, zero=1 on the next cycle.
- mul a=0xFFFFFFFD (−3), b=7 → result=0xFFFFFFEB, result_hi=0xFFFFFFFF, done 33 cycles after the start cycle. A start (add) pulsed at iteration 5 is ignored.
- div a=−17, b=5 → result=0xFFFFFFFD, result_hi=0xFFFFFFFE. div a=9, b=0 → result=0xFFFFFFFF, result_hi=9, div_by_zero=1 at full latency.
- sll b=1, shamt=31 → 0x80000000. srl b=0x80000000, shamt=31 → 1. slt a=−1, b=1 → 1. op 1111 → result=0, illegal=1.
- rst_n low during mul iteration 10 → busy, done and result all 0 immediately. After release, add a=1,b=1 → result=2 after one cycle.
- Build without ALU_MULDIV_EN: op 0010 → illegal=1, result=0, done after one cycle, busy never asserts.
